// File: rtl/gun_pkg.sv
// Shared constants, FSM state encoding and position scaling for the gun ADC reader.
package gun_pkg;

  // Gun position width per axis, as delivered by the encoder.
  localparam int unsigned POS_W = 6;

  // Defaults: 4 ms tick at 12 MHz, and the emulated conversion time.
  localparam int unsigned TICK_DIV_DEF    = 48000;
  localparam int unsigned CONV_CYCLES_DEF = 64;

  // Reader FSM state encoding. Plain constants keep the encoding visible to
  // legacy tools; the unused code 2'b11 is decoded back to idle.
  typedef logic [1:0] gun_state_t;
  localparam gun_state_t StIdle = 2'd0;
  localparam gun_state_t StConv = 2'd1;
  localparam gun_state_t StDone = 2'd2;

  // Widen a 6-bit position to 8 bits by repeating the top bits into the low
  // bits, so that 0 maps to 0x00 and full scale maps to 0xFF.
  function automatic logic [7:0] pos_to_8bit(input logic [POS_W-1:0] pos);
    return {pos, pos[POS_W-1 -: 2]};
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running tick divider: counts 0..TICK_DIV-1, produces a registered
// square wave that is high for the upper half of the period, and a strobe
// that is valid in the cycle whose clock edge makes the square wave rise.
module tick_divider #(
  parameter int unsigned TICK_DIV = 48000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sq_o,
  output logic rise_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(TICK_DIV / 2);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sq_q, sq_d;

  // Next count with wrap, and the square wave derived from the next count so
  // that the registered output always matches the registered counter.
  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    sq_d  = (cnt_d >= CntHalf);
  end

  // Counter and square-wave state, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end

  assign sq_o   = sq_q;
  // High in the cycle before sq_o goes 0->1, so consumers can act on that same edge.
  assign rise_o = sq_d & ~sq_q;

endmodule

// File: rtl/gun_adc_reader.sv
// Game-side reader for the emulated gun position. Generates the encoder tick,
// snapshots both axes coherently on each tick rise, and answers CPU reads
// through a start/busy/data_valid handshake with a fixed conversion latency.
module gun_adc_reader
  import gun_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
  parameter int unsigned CONV_CYCLES = CONV_CYCLES_DEF
) (
  input  logic             clock_12,
  input  logic             reset_n,
  input  logic [POS_W-1:0] gun_h,
  input  logic [POS_W-1:0] gun_v,
  output logic             cnt_4ms_o,
  input  logic             start,
  input  logic             sel,
  output logic             busy,
  output logic             data_valid,
  output logic [7:0]       data_out,
  output logic             overrun
);

  localparam int unsigned ConvW = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
  // Loaded on acceptance; together with the DONE cycle and the registered
  // outputs this places data_valid CONV_CYCLES edges after the start edge.
  localparam logic [ConvW-1:0] ConvLoad = ConvW'(CONV_CYCLES - 2);

  logic tick_rise;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk_i  (clock_12),
    .rst_ni (reset_n),
    .sq_o   (cnt_4ms_o),
    .rise_o (tick_rise)
  );

  logic [POS_W-1:0] shadow_h_q, shadow_h_d;
  logic [POS_W-1:0] shadow_v_q, shadow_v_d;
  gun_state_t       state_q, state_d;
  logic [POS_W-1:0] conv_val_q, conv_val_d;
  logic [ConvW-1:0] conv_cnt_q, conv_cnt_d;
  logic             busy_q, busy_d;
  logic             data_valid_q, data_valid_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             overrun_q, overrun_d;

  // Both axes update on the same edge so a read never mixes old and new samples.
  always_comb begin
    shadow_h_d = shadow_h_q;
    shadow_v_d = shadow_v_q;
    if (tick_rise) begin
      shadow_h_d = gun_h;
      shadow_v_d = gun_v;
    end
  end

  // Conversion FSM: accept in idle, count down, publish in done.
  always_comb begin
    state_d      = state_q;
    conv_val_d   = conv_val_q;
    conv_cnt_d   = conv_cnt_q;
    busy_d       = busy_q;
    data_valid_d = 1'b0;
    data_out_d   = data_out_q;
    overrun_d    = overrun_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          // The value is frozen here; later snapshots do not affect this read.
          conv_val_d = sel ? shadow_v_q : shadow_h_q;
          conv_cnt_d = ConvLoad;
          busy_d     = 1'b1;
          overrun_d  = 1'b0;
          state_d    = StConv;
        end
      end
      StConv: begin
        if (start) begin
          overrun_d = 1'b1;
        end
        if (conv_cnt_q == '0) begin
          state_d = StDone;
        end else begin
          conv_cnt_d = conv_cnt_q - 1'b1;
        end
      end
      StDone: begin
        // A start on the edge where busy falls is still treated as busy.
        if (start) begin
          overrun_d = 1'b1;
        end
        data_out_d   = pos_to_8bit(conv_val_q);
        data_valid_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reader state; reset aborts any conversion without issuing data_valid.
  always_ff @(posedge clock_12) begin
    if (!reset_n) begin
      shadow_h_q   <= '0;
      shadow_v_q   <= '0;
      state_q      <= StIdle;
      conv_val_q   <= '0;
      conv_cnt_q   <= '0;
      busy_q       <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      shadow_h_q   <= shadow_h_d;
      shadow_v_q   <= shadow_v_d;
      state_q      <= state_d;
      conv_val_q   <= conv_val_d;
      conv_cnt_q   <= conv_cnt_d;
      busy_q       <= busy_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
      overrun_q    <= overrun_d;
    end
  end

  assign busy       = busy_q;
  assign data_valid = data_valid_q;
  assign data_out   = data_out_q;
  assign overrun    = overrun_q;

endmodule
